// File: rtl/anim_pkg.sv
// anim_pkg: shared state enum, default constants and speed-to-step mapping for anim_rate_ctrl
package anim_pkg;
  typedef enum logic [1:0] {RUN, PAUSED, STEP} state_t;
  localparam int DEF_STEP_UNIT = 4;
  localparam int DEF_MIN_STEP  = 2;
  localparam int DEF_MAX_SPEED = 6;
  function automatic int speed_to_step(int spd, int unit, int min_step, int max_speed, int step_max);
    return (spd >= 2 && spd <= max_speed) ? ((spd * unit > step_max) ? step_max : spd * unit) : min_step;
  endfunction
endpackage

// File: rtl/anim_rate_ctrl_if.sv
// anim_rate_ctrl_if: control inputs and animation state outputs of anim_rate_ctrl
interface anim_rate_ctrl_if #(parameter int SPEED_W = 3, parameter int STEP_W = 12, parameter int POS_W = 16);
  logic               frame_tick;
  logic [SPEED_W-1:0] speed;
  logic               pause;
  logic               resume;
  logic               single_step;
  logic               reverse;
  logic               paused;
  logic [STEP_W-1:0]  step_size;
  logic [STEP_W-1:0]  target_step;
  logic [POS_W-1:0]   position;
  logic               advance;
  logic               ramping;
  modport master(output frame_tick, speed, pause, resume, single_step, reverse,
                 input paused, step_size, target_step, position, advance, ramping);
  modport slave(input frame_tick, speed, pause, resume, single_step, reverse,
                output paused, step_size, target_step, position, advance, ramping);
endinterface

// File: rtl/anim_rate_ctrl_step_ramp.sv
// step_ramp: step_size register that slews toward target by at most RAMP_INC per enabled tick
module step_ramp #(
  parameter int STEP_W   = 12,
  parameter int MIN_STEP = 2,
  parameter int RAMP_INC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_en,
  input  logic [STEP_W-1:0] target,
  output logic [STEP_W-1:0] step
);
  localparam logic [STEP_W-1:0] INC = STEP_W'(RAMP_INC);
  logic              up;
  logic [STEP_W-1:0] diff, delta, nxt;
  always_comb begin
    up    = target > step;
    diff  = up ? target - step : step - target;
    delta = (RAMP_INC == 0 || diff <= INC) ? diff : INC;
    nxt   = up ? step + delta : step - delta;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) step <= STEP_W'(MIN_STEP);
    else if (tick_en) step <= nxt;
endmodule

// File: rtl/anim_rate_ctrl.sv
// anim_rate_ctrl: frame-rate animation controller with ramped step, pause/single-step and
// a wrapping fixed-point position accumulator
module anim_rate_ctrl
  import anim_pkg::*;
#(
  parameter int SPEED_W   = 3,
  parameter int STEP_W    = 12,
  parameter int FRAC_W    = 4,
  parameter int POS_W     = 16,
  parameter int STEP_UNIT = DEF_STEP_UNIT,
  parameter int MIN_STEP  = DEF_MIN_STEP,
  parameter int MAX_SPEED = DEF_MAX_SPEED,
  parameter int RAMP_INC  = 2
) (
  input logic            clk,
  input logic            rst,
  anim_rate_ctrl_if.slave bus
);
  if (FRAC_W >= STEP_W || FRAC_W >= POS_W) begin : g_bad_frac
    $error("FRAC_W must be narrower than STEP_W and POS_W");
  end
  state_t             state, state_n;
  logic               adv, ramp_en, adv_q;
  logic [SPEED_W-1:0] spd;
  logic [STEP_W-1:0]  target, step;
  logic [POS_W-1:0]   pos;
  assign spd    = bus.speed;
  assign target = STEP_W'(speed_to_step(int'(spd), STEP_UNIT, MIN_STEP, MAX_SPEED, (1 << STEP_W) - 1));
  always_comb begin
    state_n = state;
    adv     = 1'b0;
    ramp_en = 1'b0;
    state_n = bus.pause ? PAUSED :
              state == PAUSED ? (bus.resume ? RUN : bus.single_step ? STEP : PAUSED) :
              state == STEP ? (bus.resume ? RUN : bus.frame_tick ? PAUSED : STEP) : RUN;
    adv     = bus.frame_tick && !bus.pause && (state == RUN || (state == STEP && !bus.resume));
    ramp_en = bus.frame_tick && !bus.pause && state == RUN;
  end
  // position uses the pre-ramp step_size of the same frame
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      adv_q <= 1'b0;
      pos   <= '0;
    end else begin
      state <= state_n;
      adv_q <= adv;
      if (adv) pos <= bus.reverse ? pos - POS_W'(step) : pos + POS_W'(step);
    end
  step_ramp #(.STEP_W(STEP_W), .MIN_STEP(MIN_STEP), .RAMP_INC(RAMP_INC)) u_ramp (
    .clk(clk), .rst(rst), .tick_en(ramp_en), .target(target), .step(step)
  );
  assign bus.paused      = state != RUN;
  assign bus.step_size   = step;
  assign bus.target_step = target;
  assign bus.position    = pos;
  assign bus.advance     = adv_q;
  assign bus.ramping     = step != target;
endmodule

// File: tb/tb_anim_rate_ctrl.sv
// tb_anim_rate_ctrl: directed + randomized checks of two builds (ramped/16-bit, immediate/8-bit)
module tb_anim_rate_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic tick, pause, resume, sstep, rev;
  logic [2:0] speed;
  int n_chk = 0;
  int n_err = 0;
  int m_mode[2], m_step[2], m_pos[2], m_adv[2];
  int rinc[2] = '{2, 0};
  int pw[2]   = '{16, 8};
  int exp_pos[4] = '{2, 6, 12, 20};
  int nadv, p0, s0;
  always #5 clk = ~clk;
  anim_rate_ctrl_if #(.SPEED_W(3), .STEP_W(12), .POS_W(16)) b0 ();
  anim_rate_ctrl_if #(.SPEED_W(3), .STEP_W(12), .POS_W(8))  b1 ();
  assign b0.frame_tick = tick;  assign b1.frame_tick = tick;
  assign b0.speed = speed;      assign b1.speed = speed;
  assign b0.pause = pause;      assign b1.pause = pause;
  assign b0.resume = resume;    assign b1.resume = resume;
  assign b0.single_step = sstep; assign b1.single_step = sstep;
  assign b0.reverse = rev;      assign b1.reverse = rev;
  anim_rate_ctrl #(.SPEED_W(3), .STEP_W(12), .FRAC_W(4), .POS_W(16), .RAMP_INC(2)) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave));
  anim_rate_ctrl #(.SPEED_W(3), .STEP_W(12), .FRAC_W(4), .POS_W(8), .RAMP_INC(0)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave));
  function automatic int tgt_of(int s);
    return (s >= 2 && s <= 6) ? ((s * 4 > 4095) ? 4095 : s * 4) : 2;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_step[k] = 2; m_pos[k] = 0; m_adv[k] = 0;
    end
  endtask
  // mode: 0 running, 1 paused, 2 single step pending
  task automatic model_tick;
    int t, d;
    bit run_frame, step_frame;
    t = tgt_of(int'(speed));
    for (int k = 0; k < 2; k++) begin
      run_frame  = tick && m_mode[k] == 0 && !pause;
      step_frame = tick && m_mode[k] == 2 && !pause && !resume;
      m_adv[k] = (run_frame || step_frame) ? 1 : 0;
      if (m_adv[k] != 0) m_pos[k] = (m_pos[k] + (rev ? -m_step[k] : m_step[k])) & ((1 << pw[k]) - 1);
      if (run_frame) begin
        d = t - m_step[k];
        if (rinc[k] == 0 || (d <= rinc[k] && -d <= rinc[k])) m_step[k] = t;
        else m_step[k] += (d > 0) ? rinc[k] : -rinc[k];
      end
      if (pause) m_mode[k] = 1;
      else if (m_mode[k] == 1) m_mode[k] = resume ? 0 : sstep ? 2 : 1;
      else if (m_mode[k] == 2) m_mode[k] = resume ? 0 : tick ? 1 : 2;
    end
  endtask
  task automatic check_all;
    int t;
    t = tgt_of(int'(speed));
    chk("pos0", 32'(b0.position), m_pos[0]);
    chk("step0", 32'(b0.step_size), m_step[0]);
    chk("adv0", 32'(b0.advance), m_adv[0]);
    chk("paused0", 32'(b0.paused), (m_mode[0] != 0) ? 1 : 0);
    chk("tgt0", 32'(b0.target_step), t);
    chk("ramp0", 32'(b0.ramping), (m_step[0] != t) ? 1 : 0);
    chk("pos1", 32'(b1.position), m_pos[1]);
    chk("step1", 32'(b1.step_size), m_step[1]);
    chk("adv1", 32'(b1.advance), m_adv[1]);
    chk("paused1", 32'(b1.paused), (m_mode[1] != 0) ? 1 : 0);
    chk("tgt1", 32'(b1.target_step), t);
    chk("ramp1", 32'(b1.ramping), (m_step[1] != t) ? 1 : 0);
  endtask
  task automatic cyc;
    @(posedge clk);
    model_tick();
    #1;
    check_all();
  endtask
  initial begin
    rst = 1'b1; tick = 0; pause = 0; resume = 0; sstep = 0; rev = 0; speed = 3'd4;
    model_reset();
    #12;
    check_all();
    @(posedge clk); #1;
    rst = 1'b0;
    cyc();
    for (int i = 1; i <= 7; i++) begin
      tick = 1; cyc(); tick = 0;
      if (i <= 4) chk("ramp_pos", 32'(b0.position), exp_pos[i-1]);
      if (i == 6) chk("ramping_mid", 32'(b0.ramping), 1);
      cyc();
    end
    chk("ramp_done", 32'(b0.ramping), 0);
    chk("ramp_final", 32'(b0.step_size), 16);
    speed = 3'd6; tick = 1; cyc(); tick = 0;
    chk("imm_24", 32'(b1.step_size), 24);
    speed = 3'd1; tick = 1; cyc(); tick = 0;
    chk("imm_2", 32'(b1.step_size), 2);
    speed = 3'd7; #1;
    chk("tgt_spd7", 32'(b0.target_step), 2);
    speed = 3'd0; #1;
    chk("tgt_spd0", 32'(b0.target_step), 2);
    speed = 3'd5;
    cyc();
    p0 = int'(b0.position);
    tick = 1; pause = 1; cyc(); tick = 0; pause = 0;
    chk("pause_noadv", 32'(b0.advance), 0);
    chk("pause_pos", 32'(b0.position), p0);
    chk("pause_flag", 32'(b0.paused), 1);
    s0 = int'(b0.step_size);
    sstep = 1; cyc(); sstep = 0; cyc();
    sstep = 1; cyc(); sstep = 0;
    nadv = 0;
    for (int i = 0; i < 3; i++) begin
      tick = 1; cyc(); tick = 0; nadv += int'(b0.advance);
      cyc(); nadv += int'(b0.advance);
    end
    chk("single_count", nadv, 1);
    chk("single_pos", 32'(b0.position), (p0 + s0) & 16'hFFFF);
    chk("single_paused", 32'(b0.paused), 1);
    resume = 1; cyc(); resume = 0;
    tick = 1; cyc(); tick = 0; cyc();
    #3; rst = 1'b1; #1;
    model_reset();
    check_all();
    chk("arst_pos", 32'(b0.position), 0);
    #2; rst = 1'b0;
    rev = 1; tick = 1; cyc(); tick = 0; rev = 0;
    chk("wrap16", 32'(b0.position), 32'hFFFE);
    chk("wrap8", 32'(b1.position), 32'hFE);
    for (int i = 0; i < 400; i++) begin
      tick   = ($urandom % 3) == 0;
      pause  = ($urandom % 16) == 0;
      resume = ($urandom % 8) == 0;
      sstep  = ($urandom % 6) == 0;
      if (($urandom % 10) == 0) rev = $urandom % 2;
      if (($urandom % 20) == 0) speed = 3'($urandom % 8);
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/anim_rate_ctrl.md
# anim_rate_ctrl

Parametrised frame-rate animation controller that generalises the fixed speed-to-step mapping. It adds programmable step scaling, ramped (smooth) speed changes, single-frame stepping while paused, direction control, and an internal wrapping fixed-point position accumulator. It sits between the VGA timing generator (frame tick) and the pattern generators, and replaces ad-hoc per-pattern position counters.

## Interface
Parameters:
- SPEED_W, 3, width of speed select
- STEP_W, 12, width of step_size (fixed point, FRAC_W fractional bits)
- FRAC_W, 4, fractional bits of step and position
- POS_W, 16, position accumulator width
- STEP_UNIT, 4, step per speed code
- MIN_STEP, 2, step for codes 0, 1 and codes above MAX_SPEED
- MAX_SPEED, 6, highest valid speed code
- RAMP_INC, 2, max step change per frame; 0 = immediate

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame (vsync rising)
- speed  in  SPEED_W  speed select
- pause  in  1  enter pause (level, sampled each cycle)
- resume  in  1  leave pause
- single_step  in  1  request one frame advance while paused
- reverse  in  1  1 = position decrements
- paused  out  1  1 in PAUSED or STEP state
- step_size  out  STEP_W  current (ramped) step
- target_step  out  STEP_W  combinational target from speed
- position  out  POS_W  accumulator; integer part = position[POS_W-1:FRAC_W]
- advance  out  1  one-cycle pulse on the cycle position updates
- ramping  out  1  step_size != target_step

## Operation
- Target: speed in 2..MAX_SPEED gives speed*STEP_UNIT, saturated to 2^STEP_W-1; otherwise MIN_STEP.
- FSM states RUN, PAUSED, STEP. Priority: pause > resume > single_step.
  - RUN: pause -> PAUSED; single_step ignored.
  - PAUSED: resume -> RUN; single_step -> STEP.
  - STEP: pause -> PAUSED (cancels pending step); resume -> RUN; a frame_tick with neither asserted advances once and returns to PAUSED. Further single_step pulses are not queued.
- Advance frame: frame_tick in RUN with pause low, or frame_tick in STEP with pause and resume low. A resume coinciding with a tick in PAUSED does not advance.
- On an advance frame, position <= position + step_size, or - step_size if reverse. The update wraps modulo 2^POS_W and uses step_size before this frame's ramp update.
- Ramp: on every frame_tick in RUN (pause low), step_size moves toward target_step by min(RAMP_INC, |difference|). RAMP_INC=0 loads the target directly. There is no ramp in PAUSED or STEP, so single steps use the frozen step_size. A speed change mid-ramp retargets from the current value.
- A reverse change takes effect on the next advance; no ramp through zero.

## Timing
- Reset values: state RUN, paused 0, step_size MIN_STEP, position 0, advance 0. ramping reflects the reset step_size against the current target.
- All outputs except target_step and ramping are registered. target_step is combinational from speed; ramping is combinational from the registered step_size and target_step.
- paused changes one cycle after the pause/resume/single_step sample edge.
- advance asserts in the cycle after frame_tick is sampled, together with the new position and the new ramped step_size.
- Async reset mid-frame clears everything immediately; the first tick after release advances by MIN_STEP.

## Structure
- Package anim_pkg holds:
  - the state enum (RUN, PAUSED, STEP)
  - default constants for STEP_UNIT, MIN_STEP, MAX_SPEED
  - a speed-to-step function
- Sub-module step_ramp owns the step_size register and saturating move-toward-target logic, with inputs tick_en, target, RAMP_INC.

## Test plan
- Reset, speed=4, RAMP_INC=2, 4 ticks -> step_size 2,4,6,8; position 0x0002,0x0006,0x000C,0x0014; ramping deasserts after 7 ticks at step_size 16.
- RAMP_INC=0, speed 6->1 -> step_size 24 then 2 on the next tick; speed=7 and speed=0 -> target_step 2.
- pause asserted in the same cycle as frame_tick -> no advance pulse, position unchanged, paused=1 next cycle.
- PAUSED, single_step, then 3 ticks -> exactly one advance (by frozen step_size), back in PAUSED; a second single_step during STEP is not queued.
- reverse=1, position 0x0004, step 8 -> position 0xFFFC (wrap); POS_W=8 build wraps at 0x100.
- Assert rst asynchronously mid-ramp -> all outputs are at reset values before the next clk edge.
